// File: rtl/hood_display.sv
// -----------------------------------------------------------------------------
// hood_display
//   Display stage of the range hood. Shows one of four pages on an
//   8-digit multiplexed 7-segment panel. The panel is scanned as two
//   4-digit groups driven together. All displayed values are frozen at
//   the start of each scan frame, so one frame never mixes old and new data.
//
//   Optional feature macro: HOOD_DISP_BLINK_EN. When it is defined, the
//   panel blinks while remind=1. When it is not defined, remind is ignored.
//
// Parameters
//   SCAN_DIV   clocks per digit slot
//   BLINK_DIV  clocks per blink half-period (HOOD_DISP_BLINK_EN only)
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   power_on              0 blanks the panel and holds the scan at frame start
//   page_btn              debounced level; each rising edge advances the page
//   cur_hour/min/second   wall-clock time (page 0)
//   work_hours/minutes    cumulative work time (page 1)
//   state_smoke_lvl       smoke/mode level (page 2)
//   countsecond           cleaning countdown (page 2)
//   hand_time             gesture-switch time (page 3)
//   remind                cleaning-reminder flag (blink source)
//   seg_en                digit enables, bit7 = leftmost position
//   seg_left/seg_right    segments {a..g,dp} for positions 0-3 / 4-7
//   page                  current page register
// -----------------------------------------------------------------------------
module hood_display #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_on,
    input  logic       page_btn,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_second,
    input  logic [5:0] work_hours,
    input  logic [5:0] work_minutes,
    input  logic [3:0] state_smoke_lvl,
    input  logic [5:0] countsecond,
    input  logic [5:0] hand_time,
    input  logic       remind,
    output logic [7:0] seg_en,
    output logic [7:0] seg_left,
    output logic [7:0] seg_right,
    output logic [1:0] page
);

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [7:0]       SEG_DASH  = 8'h02;
    localparam logic [7:0]       SEG_BLANK = 8'h00;

    typedef struct packed {
        logic [5:0] hour;
        logic [5:0] minute;
        logic [5:0] second;
        logic [5:0] work_h;
        logic [5:0] work_m;
        logic [3:0] lvl;
        logic [5:0] cnt;
        logic [5:0] hand;
        logic [1:0] page;
    } snap_t;

    function automatic logic [7:0] digit_code(input logic [3:0] d);
        case (d)
            4'd0:    digit_code = 8'hFC;
            4'd1:    digit_code = 8'h60;
            4'd2:    digit_code = 8'hDA;
            4'd3:    digit_code = 8'hF2;
            4'd4:    digit_code = 8'h66;
            4'd5:    digit_code = 8'hB6;
            4'd6:    digit_code = 8'hBE;
            4'd7:    digit_code = 8'hE0;
            4'd8:    digit_code = 8'hFE;
            4'd9:    digit_code = 8'hF6;
            default: digit_code = SEG_BLANK;
        endcase
    endfunction

    // The inputs never exceed 63, so every field has exactly two digits.
    function automatic logic [15:0] two_digits(input logic [5:0] v);
        two_digits = {digit_code(4'(v / 6'd10)), digit_code(4'(v % 6'd10))};
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       page_q, page_d;
    logic             btn_prev_q;
    snap_t            snap_q, snap_d;
    logic [7:0]       seg_en_q, seg_en_d;
    logic [7:0]       seg_left_q, seg_left_d;
    logic [7:0]       seg_right_q, seg_right_d;
    logic             frame_start;
    logic [63:0]      row;
    logic [5:0]       lsb_left, lsb_right;

`ifdef HOOD_DISP_BLINK_EN
    localparam int              BLK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;

    // Clearing the counter whenever remind is low means that each reminder
    // starts with a visible half-period.
    always_comb begin
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (!remind) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end
`else
    logic unused_remind;
    assign unused_remind = remind;
`endif

    // NOTE: every signal written in this block gets a default first. That
    // way no path leaves a value unassigned, and no latch is inferred.
    always_comb begin
        div_d  = div_q + 1'b1;
        idx_d  = idx_q;
        page_d = page_q;
        snap_d = snap_q;

        if (!power_on) begin
            // Power off holds the scan at frame start, so a new snapshot is
            // taken every cycle.
            div_d = '0;
            idx_d = 2'd0;
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end

        // Page edges are ignored while the hood is off, but the page is kept.
        if (power_on && page_btn && !btn_prev_q)
            page_d = page_q + 2'd1;

        // The snapshot takes page_q. A page edge on this same cycle
        // therefore shows from the next frame.
        frame_start = (idx_q == 2'd0) && (div_q == '0);
        if (frame_start) begin
            snap_d.hour   = cur_hour;
            snap_d.minute = cur_min;
            snap_d.second = cur_second;
            snap_d.work_h = work_hours;
            snap_d.work_m = work_minutes;
            snap_d.lvl    = state_smoke_lvl;
            snap_d.cnt    = countsecond;
            snap_d.hand   = hand_time;
            snap_d.page   = page_q;
        end

        // Decoding from snap_d means the first slot of a frame already shows
        // the data just captured. Every slot of a frame uses one snapshot.
        // row holds pos0 in [63:56] and pos7 in [7:0].
        case (snap_d.page)
            2'd0: row = {two_digits(snap_d.hour), SEG_DASH, two_digits(snap_d.minute),
                         SEG_DASH, two_digits(snap_d.second)};
            2'd1: row = {digit_code(4'd1), SEG_DASH, two_digits(snap_d.work_h),
                         SEG_DASH, two_digits(snap_d.work_m), SEG_BLANK};
            2'd2: row = {digit_code(4'd2), SEG_DASH,
                         (snap_d.lvl >= 4'd10) ? SEG_DASH : digit_code(snap_d.lvl),
                         SEG_BLANK, SEG_BLANK, SEG_DASH, two_digits(snap_d.cnt)};
            default: row = {digit_code(4'd3), SEG_DASH, {4{SEG_BLANK}},
                            two_digits(snap_d.hand)};
        endcase

        // Slot k shows pos k and pos k+4. Their byte offsets are 7-k and 3-k,
        // which are {1,~k} and {0,~k} for k in 0..3.
        lsb_left  = {1'b1, ~idx_q, 3'b000};
        lsb_right = {1'b0, ~idx_q, 3'b000};

        seg_en_d    = 8'b1000_1000 >> idx_q;
        seg_left_d  = row[lsb_left +: 8];
        seg_right_d = row[lsb_right +: 8];
`ifdef HOOD_DISP_BLINK_EN
        if (remind && blink_phase_q)
            seg_en_d = '0;
`endif
        if (!power_on) begin
            seg_en_d    = '0;
            seg_left_d  = '0;
            seg_right_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments. Then every
    // register samples its pre-edge value, whatever order the lines are in.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            idx_q       <= 2'd0;
            page_q      <= 2'd0;
            btn_prev_q  <= 1'b0;
            snap_q      <= '0;
            seg_en_q    <= '0;
            seg_left_q  <= '0;
            seg_right_q <= '0;
        end else begin
            div_q       <= div_d;
            idx_q       <= idx_d;
            page_q      <= page_d;
            btn_prev_q  <= page_btn;
            snap_q      <= snap_d;
            seg_en_q    <= seg_en_d;
            seg_left_q  <= seg_left_d;
            seg_right_q <= seg_right_d;
        end
    end

    assign seg_en    = seg_en_q;
    assign seg_left  = seg_left_q;
    assign seg_right = seg_right_q;
    assign page      = page_q;

endmodule

// File: tb/tb_hood_display.sv
// -----------------------------------------------------------------------------
// tb_hood_display
//   Self-checking bench for hood_display, run with SCAN_DIV=4, BLINK_DIV=16.
//   A reference model builds the expected glyph of each panel position
//   from the page layouts. It uses plain division and lookup tables.
//   Inputs are randomized inside each frame. This checks that a frame only
//   shows its own snapshot.
// -----------------------------------------------------------------------------
module tb_hood_display;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 16;
    localparam int DASH  = -2;
    localparam int BLANK = -1;
    localparam logic [7:0] DIGITS [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                           8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    typedef struct {
        int hr, mn, sc, wh, wm, lvl, cnt, hand;
    } vals_t;

    logic       clk = 1'b0;
    logic       reset, power_on, page_btn, remind;
    logic [5:0] cur_hour, cur_min, cur_second, work_hours, work_minutes;
    logic [5:0] countsecond, hand_time;
    logic [3:0] state_smoke_lvl;
    logic [7:0] seg_en, seg_left, seg_right;
    logic [1:0] page;

    int checks = 0;
    int errors = 0;
    int exp_page = 0;

    always #5 clk = ~clk;

    hood_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk(clk), .reset(reset), .power_on(power_on), .page_btn(page_btn),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_second(cur_second),
        .work_hours(work_hours), .work_minutes(work_minutes),
        .state_smoke_lvl(state_smoke_lvl), .countsecond(countsecond),
        .hand_time(hand_time), .remind(remind),
        .seg_en(seg_en), .seg_left(seg_left), .seg_right(seg_right), .page(page)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic vals_t sample_inputs();
        vals_t v;
        v.hr = cur_hour;       v.mn = cur_min;      v.sc = cur_second;
        v.wh = work_hours;     v.wm = work_minutes; v.lvl = state_smoke_lvl;
        v.cnt = countsecond;   v.hand = hand_time;
        return v;
    endfunction

    task automatic drive(input vals_t v);
        cur_hour = 6'(v.hr);       cur_min = 6'(v.mn);       cur_second = 6'(v.sc);
        work_hours = 6'(v.wh);     work_minutes = 6'(v.wm);  state_smoke_lvl = 4'(v.lvl);
        countsecond = 6'(v.cnt);   hand_time = 6'(v.hand);
    endtask

    function automatic vals_t rand_vals();
        vals_t v;
        v.hr = $urandom_range(0, 63);  v.mn = $urandom_range(0, 63);
        v.sc = $urandom_range(0, 63);  v.wh = $urandom_range(0, 63);
        v.wm = $urandom_range(0, 63);  v.lvl = $urandom_range(0, 15);
        v.cnt = $urandom_range(0, 63); v.hand = $urandom_range(0, 63);
        return v;
    endfunction

    function automatic logic [7:0] glyph(input int sym);
        if (sym >= 0) return DIGITS[sym];
        if (sym == DASH) return 8'h02;
        return 8'h00;
    endfunction

    // Expected segment code at panel position p (0 = leftmost).
    function automatic logic [7:0] expect_pos(input int pg, input vals_t v, input int p);
        int s [8];
        case (pg)
            0: s = '{v.hr / 10, v.hr % 10, DASH, v.mn / 10, v.mn % 10, DASH, v.sc / 10, v.sc % 10};
            1: s = '{1, DASH, v.wh / 10, v.wh % 10, DASH, v.wm / 10, v.wm % 10, BLANK};
            2: s = '{2, DASH, (v.lvl >= 10) ? DASH : v.lvl, BLANK, BLANK, DASH,
                     v.cnt / 10, v.cnt % 10};
            default: s = '{3, DASH, BLANK, BLANK, BLANK, BLANK, v.hand / 10, v.hand % 10};
        endcase
        return glyph(s[p]);
    endfunction

    // Call this at a negedge just before a frame-start edge. The task checks
    // all four slots of one frame, at the first and the last cycle of each
    // slot. It changes the inputs mid-slot, then restores them at the end.
    task automatic check_frame(input string tag, input int snap_page);
        vals_t v;
        logic [7:0] en;
        v = sample_inputs();
        for (int k = 0; k < 4; k++) begin
            en = 8'((1 << (7 - k)) | (1 << (3 - k)));
            @(negedge clk);
            check($sformatf("%s en%0d", tag, k), seg_en, en);
            check($sformatf("%s left%0d", tag, k), seg_left, expect_pos(snap_page, v, k));
            check($sformatf("%s right%0d", tag, k), seg_right, expect_pos(snap_page, v, k + 4));
            drive(rand_vals());
`ifndef HOOD_DISP_BLINK_EN
            remind = 1'($urandom_range(0, 1));
`endif
            repeat (SCAN_DIV - 1) @(negedge clk);
            check($sformatf("%s hold_en%0d", tag, k), seg_en, en);
            check($sformatf("%s hold_left%0d", tag, k), seg_left, expect_pos(snap_page, v, k));
            check($sformatf("%s hold_right%0d", tag, k), seg_right, expect_pos(snap_page, v, k + 4));
        end
        drive(v);
    endtask

    // A power-off cycle blanks the panel and returns the scan to frame start.
    task automatic realign(input string tag);
        power_on = 1'b0;
        @(negedge clk);
        check({tag, " off_en"}, seg_en, 8'h00);
        check({tag, " off_left"}, seg_left, 8'h00);
        check({tag, " off_right"}, seg_right, 8'h00);
        power_on = 1'b1;
    endtask

    task automatic pulse_page(input string tag);
        page_btn = 1'b1;
        @(negedge clk);
        page_btn = 1'b0;
        exp_page = (exp_page + 1) % 4;
        check(tag, 8'(page), 8'(exp_page));
    endtask

    initial begin
        vals_t v;
        reset = 1'b1; power_on = 1'b0; page_btn = 1'b0; remind = 1'b0;
        v = '{hr: 12, mn: 34, sc: 56, wh: 7, wm: 5, lvl: 3, cnt: 9, hand: 42};
        drive(v);
        repeat (2) @(negedge clk);
        check("reset en", seg_en, 8'h00);
        check("reset left", seg_left, 8'h00);
        check("reset right", seg_right, 8'h00);
        check("reset page", 8'(page), 8'h00);

        // Clock page at 12:34:56 right after reset, then random clock values.
        reset = 1'b0; power_on = 1'b1;
        check_frame("p0 fixed", 0);
        for (int i = 0; i < 3; i++) begin
            drive(rand_vals());
            check_frame("p0 rand", 0);
        end

        // A held button advances the page only once.
        page_btn = 1'b1;
        repeat (40) @(negedge clk);
        exp_page = 1;
        check("held page", 8'(page), 8'(exp_page));
        page_btn = 1'b0;
        v = sample_inputs(); v.wh = 7; v.wm = 5; drive(v);
        realign("work");
        check_frame("p1 work", 1);
        drive(rand_vals());
        check_frame("p1 rand", 1);

        // A page edge on the frame-start cycle: the register moves now,
        // and the panel follows from the next frame.
        page_btn = 1'b1;
        check_frame("fs edge", 1);
        exp_page = 2;
        check("fs edge page", 8'(page), 8'(exp_page));
        page_btn = 1'b0;
        v = sample_inputs(); v.lvl = 12; v.cnt = 9; drive(v);
        check_frame("p2 lvl12", 2);
        for (int i = 0; i < 3; i++) begin
            drive(rand_vals());
            check_frame("p2 rand", 2);
        end

        pulse_page("page to 3");
        drive(rand_vals());
        realign("p3");
        check_frame("p3 rand", 3);
        pulse_page("page wrap 0");
        realign("p0b");
        check_frame("p0 after wrap", 0);

        // Power drop in slot 2. Page edges are ignored while the hood is off.
        repeat (2 * SCAN_DIV + 1) @(negedge clk);
        check("pre-off slot2", seg_en, 8'h22);
        power_on = 1'b0;
        @(negedge clk);
        check("off en", seg_en, 8'h00);
        check("off left", seg_left, 8'h00);
        check("off right", seg_right, 8'h00);
        page_btn = 1'b1;
        @(negedge clk);
        page_btn = 1'b0;
        @(negedge clk);
        check("off page held", 8'(page), 8'(exp_page));
        drive(rand_vals());
        power_on = 1'b1;
        check_frame("repower", 0);

        // Reset wins over a page edge on the same cycle.
        pulse_page("page to 1");
        page_btn = 1'b1; reset = 1'b1;
        @(negedge clk);
        exp_page = 0;
        check("rst page", 8'(page), 8'(exp_page));
        check("rst en", seg_en, 8'h00);
        check("rst left", seg_left, 8'h00);
        page_btn = 1'b0; reset = 1'b0;
        drive(rand_vals());
        check_frame("post reset", 0);

`ifdef HOOD_DISP_BLINK_EN
        realign("blink");
        remind = 1'b1;
        for (int i = 0; i < 2 * BLINK_DIV; i++) begin
            @(negedge clk);
            check("blink on", {7'b0, seg_en != 8'h00}, {7'b0, i < BLINK_DIV});
        end
        remind = 1'b0;
        for (int i = 0; i < 2 * BLINK_DIV; i++) begin
            @(negedge clk);
            check("blink off", {7'b0, seg_en != 8'h00}, 8'h01);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
